// File: rtl/rf_port_sched.sv
// Purpose: arbitrates the single register-file write port between CPU writeback, debug
//   accesses and (when RF_SCHED_CLEAR_EN is defined) a 31-cycle register clear sequencer.
// Latency: writes reach the port in the same cycle; debug read acks one cycle after the
//   request cycle. Backpressure: cpu_stall holds the CPU writeback/PC while it is pre-empted.
module rf_port_sched #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_wr,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [4:0]  rf_sel,
  input  logic [31:0] rf_sel_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1
`ifdef RF_SCHED_CLEAR_EN
    ,
    S_CLEAR   = 2'd2
`endif
  } state_t;

  // Four bits covers the whole 1..15 range of the starvation limit.
  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_nxt;
  logic [31:0] r_dbg_rdata;

  logic        w_dbg_wr_pend;
  logic        w_dbg_rd_pend;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;
  logic [4:0]  w_rf_sel;
  logic        w_stall;
  logic        w_ack;
  logic        w_rd_cap;

`ifdef RF_SCHED_CLEAR_EN
  logic [4:0]  r_clr_idx;
  logic        r_clr_done;
  logic        w_clr_entry;
  logic        w_clr_last;
`endif

  // The requester holds dbg_req until the ack, so a high request in IDLE is pending work.
  assign w_dbg_wr_pend = dbg_req & dbg_wr;
  assign w_dbg_rd_pend = dbg_req & ~dbg_wr;

  // Port arbitration and next-state decode
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_rf_we     = 1'b0;
    w_rf_waddr  = 5'd0;
    w_rf_wdata  = 32'd0;
    w_rf_sel    = 5'd0;
    w_stall     = 1'b0;
    w_ack       = 1'b0;
    w_rd_cap    = 1'b0;
`ifdef RF_SCHED_CLEAR_EN
    w_clr_entry = 1'b0;
    w_clr_last  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef RF_SCHED_CLEAR_EN
        // Clear start wins over everything; debug requests simply stay pending.
        if (clr_start) begin
          w_state_nxt = S_CLEAR;
          w_stall     = 1'b1;
          w_clr_entry = 1'b1;
        end else
`endif
        begin
          if (w_dbg_wr_pend && (!wb_we || (r_wait_cnt == LP_MAX_WAIT))) begin
            // Debug write takes the port; a competing writeback is held off.
            w_rf_we    = 1'b1;
            w_rf_waddr = dbg_addr;
            w_rf_wdata = dbg_wdata;
            w_ack      = 1'b1;
            w_stall    = wb_we;
            w_wait_nxt = 4'd0;
          end else if (wb_we) begin
            w_rf_we    = 1'b1;
            w_rf_waddr = wb_rd;
            w_rf_wdata = wb_data;
            // Count how long the debug write has been starved by writeback.
            if (w_dbg_wr_pend) begin
              w_wait_nxt = r_wait_cnt + 4'd1;
            end
          end
          // Reads use the separate select port, so writeback keeps flowing. The value
          // captured at the edge is the pre-write contents of the register.
          if (w_dbg_rd_pend) begin
            w_rf_sel    = dbg_addr;
            w_rd_cap    = 1'b1;
            w_state_nxt = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        // Read data is already registered; acknowledge and ignore requests this cycle.
        w_ack       = 1'b1;
        w_state_nxt = S_IDLE;
        if (wb_we) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = wb_rd;
          w_rf_wdata = wb_data;
        end
      end
`ifdef RF_SCHED_CLEAR_EN
      S_CLEAR: begin
        // One register zeroed per cycle; the CPU is frozen for the whole sweep.
        w_rf_we    = 1'b1;
        w_rf_waddr = r_clr_idx;
        w_rf_wdata = 32'd0;
        w_stall    = 1'b1;
        if (r_clr_idx == 5'd31) begin
          w_state_nxt = S_IDLE;
          w_clr_last  = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, starvation counter and debug read capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 4'd0;
      r_dbg_rdata <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_rd_cap) begin
        r_dbg_rdata <= rf_sel_data;
      end
    end
  end

`ifdef RF_SCHED_CLEAR_EN
  // Clear index walks 1..31; the done pulse follows the final write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_idx  <= 5'd0;
      r_clr_done <= 1'b0;
    end else begin
      r_clr_done <= w_clr_last;
      if (w_clr_entry) begin
        r_clr_idx <= 5'd1;
      end else if (w_clr_last) begin
        r_clr_idx <= 5'd0;
      end else if (r_state == S_CLEAR) begin
        r_clr_idx <= r_clr_idx + 5'd1;
      end
    end
  end

  assign clr_busy = (r_state == S_CLEAR);
  assign clr_done = r_clr_done;
`else
  logic w_unused_clr_start;
  assign w_unused_clr_start = clr_start;
  assign clr_busy           = 1'b0;
  assign clr_done           = 1'b0;
`endif

  // Combinational strobes are masked by rst so reset silences the port immediately.
  assign rf_we     = w_rf_we & ~rst;
  assign rf_waddr  = w_rf_waddr;
  assign rf_wdata  = w_rf_wdata;
  assign rf_sel    = w_rf_sel;
  assign cpu_stall = w_stall & ~rst;
  assign dbg_ack   = w_ack & ~rst;
  assign dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_rf_port_sched.sv
// Bench for rf_port_sched: behavioural register file on the ports, scoreboard queues for
// expected write-port traffic and debug read data, one task per scenario.
module tb_rf_port_sched;
  localparam int MW = 4;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        cpu_stall;
  logic        dbg_req;
  logic        dbg_wr;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_sel;
  logic [31:0] rf_sel_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rf_mem [32];
  logic [37:0] wr_q [$];
  logic [31:0] rd_q [$];

  rf_port_sched #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_sel(rf_sel), .rf_sel_data(rf_sel_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: register 0 is hardwired to zero, contents survive reset.
  always @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) rf_mem[rf_waddr] <= rf_wdata;
  end
  assign rf_sel_data = (rf_sel == 5'd0) ? 32'd0 : rf_mem[rf_sel];

  function automatic logic [37:0] port_obs();
    return rf_we ? {rf_we, rf_waddr, rf_wdata} : 38'd0;
  endfunction

  function automatic logic [31:0] pre_val(input int i);
    return 32'hC000_0000 | 32'(i);
  endfunction

  task automatic idle_in();
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
    clr_start = 1'b0;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    wb_we = we; wb_rd = rd; wb_data = d;
  endtask

  task automatic set_dbg(input logic req, input logic wr, input logic [4:0] a, input logic [31:0] d);
    dbg_req = req; dbg_wr = wr; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic preload();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); idle_in(); set_wb(1'b1, 5'(i), pre_val(i));
    end
    @(negedge clk); idle_in();
  endtask

  task automatic test_reset();
    logic [37:0] got;
    rst = 1'b1; idle_in();
    set_wb(1'b1, 5'd4, 32'h77); set_dbg(1'b1, 1'b1, 5'd2, 32'h55); clr_start = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    got = {cpu_stall, dbg_ack, clr_busy, clr_done, rf_we, dbg_rdata};
    n_checks++;
    if (got !== 38'd0) $display("FAIL reset_held: got %h want 0", got);
    else n_pass++;
    @(negedge clk); idle_in(); rst = 1'b0;
    #1;
    got = {cpu_stall, dbg_ack, clr_busy, clr_done, rf_we, dbg_rdata};
    n_checks++;
    if (got !== 38'd0 || rf_sel !== 5'd0) $display("FAIL reset_release: got %h sel %h want 0", got, rf_sel);
    else n_pass++;
  endtask

  task automatic test_writeback();
    logic [4:0]  rd_t [4];
    logic [31:0] d_t  [4];
    logic        we_t [4];
    logic [37:0] exp;
    rd_t = '{5'd5, 5'd31, 5'd0, 5'd12};
    d_t  = '{32'h1234, 32'hFFFF_FFFF, 32'h55, 32'h0BAD};
    we_t = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle_in(); set_wb(we_t[i], rd_t[i], d_t[i]);
      wr_q.push_back(we_t[i] ? {1'b1, rd_t[i], d_t[i]} : 38'd0);
      #1;
      exp = wr_q.pop_front();
      n_checks++;
      if ({port_obs(), cpu_stall, dbg_ack} !== {exp, 2'b00})
        $display("FAIL wb_pass[%0d]: got %h stall %b ack %b want %h stall 0 ack 0", i, port_obs(), cpu_stall, dbg_ack, exp);
      else n_pass++;
    end
    @(negedge clk); idle_in();
  endtask

  task automatic test_dbg_write_starve();
    logic [4:0]  a_t [2];
    logic [31:0] d_t [2];
    logic [37:0] exp;
    logic        last;
    a_t = '{5'd7, 5'd8};
    d_t = '{32'hDEAD_BEEF, 32'h0808_0808};
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k <= MW; k++) begin
        @(negedge clk); idle_in();
        set_wb(1'b1, 5'(16 + k), 32'(k + 100));
        set_dbg(1'b1, 1'b1, a_t[r], d_t[r]);
        last = (k == MW);
        wr_q.push_back(last ? {1'b1, a_t[r], d_t[r]} : {1'b1, 5'(16 + k), 32'(k + 100)});
        #1;
        exp = wr_q.pop_front();
        n_checks++;
        if ({port_obs(), cpu_stall, dbg_ack} !== {exp, last, last})
          $display("FAIL starve[%0d][%0d]: got %h stall %b ack %b want %h stall %b ack %b", r, k, port_obs(), cpu_stall, dbg_ack, exp, last, last);
        else n_pass++;
      end
      // CPU re-presents its stalled writeback once the debug write is done.
      @(negedge clk); idle_in(); set_wb(1'b1, 5'(16 + MW), 32'(MW + 100));
      #1;
      n_checks++;
      if ({port_obs(), cpu_stall, dbg_ack} !== {1'b1, 5'(16 + MW), 32'(MW + 100), 2'b00})
        $display("FAIL starve_retry[%0d]: got %h stall %b ack %b", r, port_obs(), cpu_stall, dbg_ack);
      else n_pass++;
      @(negedge clk); idle_in();
      #1;
      n_checks++;
      if (rf_mem[a_t[r]] !== d_t[r]) $display("FAIL starve_reg[%0d]: got %h want %h", r, rf_mem[a_t[r]], d_t[r]);
      else n_pass++;
    end
    // With no writeback competing, a debug write is granted at once without stalling.
    @(negedge clk); idle_in(); set_dbg(1'b1, 1'b1, 5'd8, 32'h8888_0008);
    #1;
    n_checks++;
    if ({port_obs(), cpu_stall, dbg_ack} !== {1'b1, 5'd8, 32'h8888_0008, 1'b0, 1'b1})
      $display("FAIL dbg_wr_free: got %h stall %b ack %b", port_obs(), cpu_stall, dbg_ack);
    else n_pass++;
    @(negedge clk); idle_in();
  endtask

  task automatic test_dbg_read();
    logic [4:0]  a_t [3];
    logic [31:0] e_t [3];
    logic [31:0] exp;
    a_t = '{5'd3, 5'd3, 5'd0};
    e_t = '{32'hA5A5_A5A5, 32'h1111_1111, 32'h0};
    @(negedge clk); idle_in(); set_wb(1'b1, 5'd3, 32'hA5A5_A5A5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_in(); set_dbg(1'b1, 1'b0, a_t[i], 32'd0);
      if (i == 0) set_wb(1'b1, 5'd3, 32'h1111_1111);
      rd_q.push_back(e_t[i]);
      #1;
      n_checks++;
      if ({rf_sel, dbg_ack, rf_we} !== {a_t[i], 1'b0, (i == 0)})
        $display("FAIL rd_issue[%0d]: sel %h ack %b we %b want sel %h ack 0", i, rf_sel, dbg_ack, rf_we, a_t[i]);
      else n_pass++;
      @(negedge clk); idle_in(); set_dbg(1'b1, 1'b0, a_t[i], 32'd0); set_wb(1'b1, 5'd25, 32'h2500 + 32'(i));
      #1;
      exp = rd_q.pop_front();
      n_checks++;
      if ({dbg_ack, dbg_rdata, rf_we, rf_waddr, rf_sel} !== {1'b1, exp, 1'b1, 5'd25, 5'd0})
        $display("FAIL rd_ack[%0d]: ack %b data %h we %b waddr %h sel %h want data %h", i, dbg_ack, dbg_rdata, rf_we, rf_waddr, rf_sel, exp);
      else n_pass++;
      @(negedge clk); idle_in();
      #1;
      n_checks++;
      if (dbg_ack !== 1'b0) $display("FAIL rd_ack_pulse[%0d]: ack %b want 0", i, dbg_ack);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    @(negedge clk); idle_in(); set_dbg(1'b1, 1'b1, 5'd7, 32'hCAFE_F00D);
    #1;
    n_checks++;
    if ({port_obs(), dbg_ack} !== {1'b1, 5'd7, 32'hCAFE_F00D, 1'b1})
      $display("FAIL b2b_wr: got %h ack %b", port_obs(), dbg_ack);
    else n_pass++;
    @(negedge clk); idle_in(); set_dbg(1'b1, 1'b0, 5'd7, 32'd0);
    rd_q.push_back(32'hCAFE_F00D);
    #1;
    n_checks++;
    if ({rf_sel, dbg_ack} !== {5'd7, 1'b0}) $display("FAIL b2b_rd_issue: sel %h ack %b want sel 07 ack 0", rf_sel, dbg_ack);
    else n_pass++;
    @(negedge clk);
    #1;
    exp = rd_q.pop_front();
    n_checks++;
    if ({dbg_ack, dbg_rdata} !== {1'b1, exp}) $display("FAIL b2b_rd_ack: ack %b data %h want 1 %h", dbg_ack, dbg_rdata, exp);
    else n_pass++;
    @(negedge clk); idle_in(); set_dbg(1'b1, 1'b1, 5'd6, 32'h6);
    #1;
    n_checks++;
    if ({port_obs(), dbg_ack} !== {1'b1, 5'd6, 32'h6, 1'b1}) $display("FAIL b2b_wr2: got %h ack %b", port_obs(), dbg_ack);
    else n_pass++;
    @(negedge clk); idle_in();
  endtask

  task automatic test_dbg_write_addr0();
    @(negedge clk); idle_in(); set_dbg(1'b1, 1'b1, 5'd0, 32'hFFFF);
    #1;
    n_checks++;
    if ({rf_we, rf_waddr, dbg_ack, cpu_stall} !== {1'b1, 5'd0, 1'b1, 1'b0})
      $display("FAIL wr_addr0: we %b waddr %h ack %b stall %b", rf_we, rf_waddr, dbg_ack, cpu_stall);
    else n_pass++;
    @(negedge clk); idle_in();
  endtask

  task automatic test_reset_handshake();
    @(negedge clk); idle_in(); set_dbg(1'b1, 1'b0, 5'd5, 32'd0);
    #1;
    n_checks++;
    if (rf_sel !== 5'd5) $display("FAIL hs_issue: sel %h want 05", rf_sel);
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    #1;
    n_checks++;
    if ({dbg_ack, dbg_rdata} !== 33'd0) $display("FAIL hs_reset: ack %b data %h want 0", dbg_ack, dbg_rdata);
    else n_pass++;
    @(negedge clk); idle_in(); rst = 1'b0;
    #1;
    n_checks++;
    if ({dbg_ack, rf_sel, rf_we} !== 7'd0) $display("FAIL hs_after: ack %b sel %h we %b want 0", dbg_ack, rf_sel, rf_we);
    else n_pass++;
    @(negedge clk); idle_in();
  endtask

`ifdef RF_SCHED_CLEAR_EN
  task automatic test_clear();
    logic [37:0] exp;
    int bad;
    preload();
    @(negedge clk); idle_in(); set_wb(1'b1, 5'd2, 32'hBAD0_0002); clr_start = 1'b1;
    #1;
    n_checks++;
    if ({cpu_stall, rf_we, clr_busy, dbg_ack} !== 4'b1000)
      $display("FAIL clr_entry: stall %b we %b busy %b ack %b want 1 0 0 0", cpu_stall, rf_we, clr_busy, dbg_ack);
    else n_pass++;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk); idle_in(); set_wb(1'b1, 5'd2, 32'hBAD0_0002);
      clr_start = (i == 15);
      if (i >= 5) set_dbg(1'b1, 1'b1, 5'd9, 32'h9999_0009);
      wr_q.push_back({1'b1, 5'(i), 32'd0});
      #1;
      exp = wr_q.pop_front();
      n_checks++;
      if ({port_obs(), cpu_stall, clr_busy, clr_done, dbg_ack} !== {exp, 4'b1100})
        $display("FAIL clr_cycle[%0d]: got %h stall %b busy %b done %b ack %b want %h", i, port_obs(), cpu_stall, clr_busy, clr_done, dbg_ack, exp);
      else n_pass++;
    end
    // CPU writeback goes first after the clear: the starvation count did not move.
    @(negedge clk); idle_in(); set_wb(1'b1, 5'd2, 32'hBAD0_0002); set_dbg(1'b1, 1'b1, 5'd9, 32'h9999_0009);
    #1;
    bad = 0;
    for (int r = 1; r < 32; r++) if (rf_mem[r] !== 32'd0) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL clr_regs_zero: %0d nonzero registers want 0", bad);
    else n_pass++;
    n_checks++;
    if ({clr_done, clr_busy, dbg_ack, port_obs(), cpu_stall} !== {3'b100, 1'b1, 5'd2, 32'hBAD0_0002, 1'b0})
      $display("FAIL clr_done_cycle: done %b busy %b ack %b port %h stall %b", clr_done, clr_busy, dbg_ack, port_obs(), cpu_stall);
    else n_pass++;
    @(negedge clk); idle_in(); set_dbg(1'b1, 1'b1, 5'd9, 32'h9999_0009);
    #1;
    n_checks++;
    if ({clr_done, clr_busy, dbg_ack, port_obs()} !== {3'b001, 1'b1, 5'd9, 32'h9999_0009})
      $display("FAIL clr_dbg_after: done %b busy %b ack %b port %h", clr_done, clr_busy, dbg_ack, port_obs());
    else n_pass++;
    @(negedge clk); idle_in();
    #1;
    n_checks++;
    if (rf_mem[9] !== 32'h9999_0009) $display("FAIL clr_dbg_reg: got %h want 99990009", rf_mem[9]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    int bad;
    int seen;
    preload();
    @(negedge clk); idle_in(); clr_start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); idle_in();
      #1;
      n_checks++;
      if ({rf_we, rf_waddr, clr_busy} !== {1'b1, 5'(i), 1'b1}) $display("FAIL rst_clr_cycle[%0d]: we %b waddr %h busy %b", i, rf_we, rf_waddr, clr_busy);
      else n_pass++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({cpu_stall, dbg_ack, clr_busy, clr_done, rf_we, dbg_rdata} !== 37'd0)
      $display("FAIL rst_clr_outputs: stall %b ack %b busy %b done %b we %b data %h want 0", cpu_stall, dbg_ack, clr_busy, clr_done, rf_we, dbg_rdata);
    else n_pass++;
    @(negedge clk);
    @(negedge clk); idle_in(); rst = 1'b0;
    seen = 0;
    for (int t = 0; t < 4; t++) begin
      #1;
      if (clr_done || clr_busy || rf_we) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 0) $display("FAIL rst_clr_no_done: %0d cycles with done/busy/we want 0", seen);
    else n_pass++;
    bad = 0;
    for (int r = 1; r < 10; r++) if (rf_mem[r] !== 32'd0) bad++;
    for (int r = 11; r < 32; r++) if (rf_mem[r] !== pre_val(r)) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL rst_clr_regs: %0d registers wrong want 0", bad);
    else n_pass++;
  endtask
`else
  task automatic test_clear_disabled();
    @(negedge clk); idle_in(); clr_start = 1'b1; set_wb(1'b1, 5'd4, 32'h44);
    #1;
    n_checks++;
    if ({cpu_stall, clr_busy, clr_done, port_obs()} !== {3'b000, 1'b1, 5'd4, 32'h44})
      $display("FAIL clr_off_start: stall %b busy %b done %b port %h", cpu_stall, clr_busy, clr_done, port_obs());
    else n_pass++;
    @(negedge clk); idle_in();
    #1;
    n_checks++;
    if ({cpu_stall, clr_busy, clr_done, rf_we} !== 4'b0000)
      $display("FAIL clr_off_after: stall %b busy %b done %b we %b", cpu_stall, clr_busy, clr_done, rf_we);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_in();
    test_reset();
    test_writeback();
    preload();
    test_dbg_write_starve();
    test_dbg_read();
    test_back_to_back();
    test_dbg_write_addr0();
    test_reset_handshake();
`ifdef RF_SCHED_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`else
    test_clear_disabled();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
